// File: rtl/mul_acc.sv
// Multiply-accumulate back end: folds signed/unsigned multiplier products into a
// wide accumulator and hands the result out on a valid/ready port when flushed.
module mul_acc #(
  parameter int N_BIT = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8,
  parameter int SAT   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N_BIT-1:0] product,
  input  logic               mul_type,
  input  logic [1:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   out_count,
  output logic [ACC_W-1:0]   acc_q
);

  typedef enum logic {RUN, FLUSH_WAIT} state_t;

  localparam logic [1:0] OP_ACC   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_FLUSH = 2'b11;

  state_t           state;
  logic             acc_signed;
  logic             ovf;
  logic [CNT_W-1:0] cnt;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] acc_nxt;
  logic [ACC_W:0]   a_w;
  logic [ACC_W:0]   e_w;
  logic [ACC_W:0]   sum;
  logic             ovf_now;
  logic [CNT_W-1:0] cnt_inc;
  logic             take;

  assign in_ready = (state == RUN) && !rst;
  assign take     = in_valid && in_ready;

  // One extra bit of headroom; its meaning (sign vs carry/borrow) follows acc_signed.
  always_comb begin
    ext     = mul_type ? {{(ACC_W-2*N_BIT){product[2*N_BIT-1]}}, product}
                       : {{(ACC_W-2*N_BIT){1'b0}}, product};
    a_w     = {acc_signed & acc_q[ACC_W-1], acc_q};
    e_w     = {acc_signed & ext[ACC_W-1], ext};
    sum     = (op == OP_SUB) ? (a_w - e_w) : (a_w + e_w);
    ovf_now = acc_signed ? (sum[ACC_W] ^ sum[ACC_W-1]) : sum[ACC_W];
    acc_nxt = sum[ACC_W-1:0];
    if (ovf_now && (SAT != 0)) begin
      if (acc_signed)
        acc_nxt = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
        acc_nxt = (op == OP_SUB) ? '0 : '1;
    end
    cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      acc_q      <= '0;
      acc_signed <= 1'b0;
      ovf        <= 1'b0;
      cnt        <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      out_count  <= '0;
    end else if (state == RUN) begin
      if (take) begin
        case (op)
          OP_LOAD: begin
            acc_q      <= ext;
            acc_signed <= mul_type;
            ovf        <= 1'b0;
            cnt        <= CNT_W'(1);
          end
          OP_ACC, OP_SUB: begin
            acc_q <= acc_nxt;
            ovf   <= ovf | ovf_now;
            cnt   <= cnt_inc;
          end
          OP_FLUSH: begin
            out_data  <= acc_q;
            out_ovf   <= ovf;
            out_count <= cnt;
            out_valid <= 1'b1;
            acc_q     <= '0;
            ovf       <= 1'b0;
            cnt       <= '0;
            state     <= FLUSH_WAIT;
          end
          default: ;
        endcase
      end
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        state     <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_mul_acc.sv
// Randomised and directed bench for mul_acc; runs a saturating and a wrapping
// instance side by side against an integer-arithmetic reference model.
module tb_mul_acc;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       mul_type;
  logic       out_ready;
  logic [7:0] product;
  logic [1:0] op;

  logic        in_ready_s, in_ready_w, out_valid_s, out_valid_w, out_ovf_s, out_ovf_w;
  logic [11:0] out_data_s, out_data_w, acc_s, acc_w;
  logic [7:0]  out_count_s, out_count_w;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_acc_s, m_acc_w, m_cnt;
  bit m_sg, m_ovf_s, m_ovf_w, m_wait;
  int e_data_s, e_data_w, e_cnt;
  bit e_ovf_s, e_ovf_w;

  mul_acc #(.N_BIT(4), .ACC_W(12), .CNT_W(8), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .product(product), .mul_type(mul_type), .op(op),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
    .out_ovf(out_ovf_s), .out_count(out_count_s), .acc_q(acc_s));

  mul_acc #(.N_BIT(4), .ACC_W(12), .CNT_W(8), .SAT(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .product(product), .mul_type(mul_type), .op(op),
    .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
    .out_ovf(out_ovf_w), .out_count(out_count_w), .acc_q(acc_w));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Product as an integer: signed if mul_type, and as a 12-bit pattern when the
  // accumulator is being read as unsigned.
  function automatic int ext_val(input bit asg, input bit mt, input logic [7:0] p);
    int s;
    s = mt ? ((p >= 8'd128) ? int'(p) - 256 : int'(p)) : int'(p);
    return asg ? s : (s & 4095);
  endfunction

  task automatic acc_step(inout int acc, inout bit ovf, input bit asg, input bit sub,
                          input int e, input bit sat);
    int a, r, lo, hi;
    a  = (asg && acc >= 2048) ? acc - 4096 : acc;
    r  = sub ? a - e : a + e;
    lo = asg ? -2048 : 0;
    hi = asg ? 2047 : 4095;
    if (r > hi || r < lo) begin
      ovf = 1'b1;
      if (sat) r = (r > hi) ? hi : lo;
    end
    acc = r & 4095;
  endtask

  task automatic model_reset();
    m_acc_s = 0; m_acc_w = 0; m_cnt = 0; m_sg = 0;
    m_ovf_s = 0; m_ovf_w = 0; m_wait = 0;
    e_data_s = 0; e_data_w = 0; e_cnt = 0; e_ovf_s = 0; e_ovf_w = 0;
  endtask

  task automatic model_beat(input logic [1:0] o, input logic [7:0] p, input bit mt);
    int e;
    case (o)
      2'b01: begin
        m_acc_s = ext_val(1'b1, mt, p) & 4095;
        m_acc_w = m_acc_s;
        m_sg = mt; m_ovf_s = 0; m_ovf_w = 0; m_cnt = 1;
      end
      2'b00, 2'b10: begin
        e = ext_val(m_sg, mt, p);
        acc_step(m_acc_s, m_ovf_s, m_sg, o == 2'b10, e, 1'b1);
        acc_step(m_acc_w, m_ovf_w, m_sg, o == 2'b10, e, 1'b0);
        if (m_cnt < 255) m_cnt++;
      end
      default: begin
        e_data_s = m_acc_s; e_data_w = m_acc_w; e_cnt = m_cnt;
        e_ovf_s = m_ovf_s; e_ovf_w = m_ovf_w;
        m_acc_s = 0; m_acc_w = 0; m_cnt = 0; m_ovf_s = 0; m_ovf_w = 0;
        m_wait = 1;
      end
    endcase
  endtask

  // One clock: drive, step model at the edge, then compare just after it.
  task automatic beat(input logic [1:0] o, input logic [7:0] p, input bit mt, input bit v);
    op = o; product = p; mul_type = mt; in_valid = v;
    check("in_ready_s", in_ready_s, !m_wait);
    check("in_ready_w", in_ready_w, !m_wait);
    @(posedge clk);
    if (m_wait) begin
      if (out_ready) m_wait = 0;
    end else if (v) begin
      model_beat(o, p, mt);
    end
    #1;
    in_valid = 1'b0;
    check("acc_s", acc_s, m_acc_s);
    check("acc_w", acc_w, m_acc_w);
    check("out_valid", out_valid_s, m_wait);
    if (m_wait) begin
      check("out_data_s", out_data_s, e_data_s);
      check("out_data_w", out_data_w, e_data_w);
      check("out_ovf_s", out_ovf_s, e_ovf_s);
      check("out_ovf_w", out_ovf_w, e_ovf_w);
      check("out_count", out_count_s, e_cnt);
    end
  endtask

  task automatic rand_beat(input bit v);
    beat(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom), v);
  endtask

  task automatic flush(input int hold);
    out_ready = 1'b0;
    beat(2'b11, 8'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < hold; i++) rand_beat(1'($urandom));
    out_ready = 1'b1;
    rand_beat(1'($urandom));
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; mul_type = 0; out_ready = 0; product = 0; op = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_s, 1'b0);
    check("rst_acc", acc_s, 12'h000);
    check("rst_out_valid", out_valid_s, 1'b0);
    check("rst_out_data", out_data_s, 12'h000);
    check("rst_out_count", out_count_s, 8'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready_s, 1'b1);

    // signed load then positive product
    beat(2'b01, 8'hF1, 1'b1, 1'b1);
    check("t1_load", acc_s, 12'hFF1);
    beat(2'b00, 8'h40, 1'b1, 1'b1);
    check("t1_acc", acc_s, 12'h031);
    flush(0);
    check("t1_ovf", e_ovf_s, 1'b0);

    // unsigned carry-out saturates to all ones
    beat(2'b01, 8'hE1, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) beat(2'b00, 8'hE1, 1'b0, 1'b1);
    check("t2_b18", acc_s, 12'hFD2);
    beat(2'b00, 8'hE1, 1'b0, 1'b1);
    check("t2_b19", acc_s, 12'hFFF);
    out_ready = 1'b0;
    beat(2'b11, 8'h00, 1'b0, 1'b1);
    check("t2_out_ovf", out_ovf_s, 1'b1);
    check("t2_out_count", out_count_s, 8'd19);
    out_ready = 1'b1;
    beat(2'b00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b0;

    // signed positive overflow clamps at 0x7FF
    beat(2'b01, 8'h40, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) beat(2'b00, 8'h40, 1'b1, 1'b1);
    check("t3_b31", acc_s, 12'h7C0);
    beat(2'b00, 8'h40, 1'b1, 1'b1);
    check("t3_b32", acc_s, 12'h7FF);
    check("t3_wrap", acc_w, 12'h800);
    for (int i = 0; i < 3; i++) beat(2'b00, 8'h40, 1'b1, 1'b1);
    check("t3_hold", acc_s, 12'h7FF);
    flush(1);
    check("t3_out_count", e_cnt, 35);

    // unsigned borrow
    beat(2'b01, 8'h05, 1'b0, 1'b1);
    beat(2'b10, 8'h06, 1'b0, 1'b1);
    check("t4_sat", acc_s, 12'h000);
    check("t4_wrap", acc_w, 12'hFFF);
    flush(0);

    // held result while consumer stalls
    beat(2'b01, 8'h0C, 1'b0, 1'b1);
    beat(2'b00, 8'h03, 1'b0, 1'b1);
    out_ready = 1'b0;
    beat(2'b11, 8'hAA, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) beat(2'b00, 8'h11, 1'b0, 1'b1);
    check("t5_data", out_data_s, 12'h00F);
    check("t5_count", out_count_s, 8'd2);
    out_ready = 1'b1;
    beat(2'b00, 8'h11, 1'b0, 1'b1);
    out_ready = 1'b0;
    check("t5_after_rdy", in_ready_s, 1'b1);
    check("t5_after_acc", acc_s, 12'h000);

    // reset while waiting on the consumer
    beat(2'b01, 8'h22, 1'b0, 1'b1);
    beat(2'b11, 8'h00, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", out_valid_s, 1'b0);
    check("t6_in_ready", in_ready_s, 1'b0);
    check("t6_acc", acc_s, 12'h000);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("t6_rel_ready", in_ready_s, 1'b1);

    // beat counter sticks at its maximum
    beat(2'b01, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) beat(2'b00, 8'h00, 1'b0, 1'b1);
    out_ready = 1'b0;
    beat(2'b11, 8'h00, 1'b0, 1'b1);
    check("cnt_sat", out_count_s, 8'd255);
    out_ready = 1'b1;
    beat(2'b00, 8'h00, 1'b0, 1'b0);
    out_ready = 1'b0;

    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 11));
      if (r == 0) flush(int'($urandom_range(0, 3)));
      else if (r == 1) rand_beat(1'b0);
      else if (r == 2) beat(2'b01, 8'($urandom), 1'($urandom), 1'b1);
      else beat(($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10, 8'($urandom), 1'($urandom), 1'b1);
    end
    flush(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
